// File: rtl/scsi_tgt_pkg.sv
// Shared state encoding, direction codes and default timing constants for the
// SCSI target REQ/ACK handshake engine.
package scsi_tgt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_REQ_WAIT = 3'd2,
    ST_LATCH    = 3'd3,
    ST_REL_WAIT = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } tgt_state_e;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  localparam int unsigned DATA_W_DEFAULT  = 8;
  localparam int unsigned SETTLE_DEFAULT  = 2;
  localparam int unsigned TIMEOUT_DEFAULT = 50000;
  localparam int unsigned CNT_W_DEFAULT   = 16;

endpackage

// File: rtl/sync2_asyncres.sv
// Two-flop synchroniser with asynchronous active-low reset to a configurable
// preset value; shared by several asynchronous inputs across the CPLD.
module sync2_asyncres #(
  parameter int unsigned  W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/scsi_target_handshake.sv
// Target-side SCSI REQ/ACK single-byte handshake engine paced against nACK.
// Optional bus parity (db_p_out, db_p_in, tgt_perr) is built when SCSI_TGT_PARITY_EN is defined.
module scsi_target_handshake
  import scsi_tgt_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEFAULT,
  parameter int unsigned SETTLE_CYCLES  = SETTLE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = CNT_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              nCLR,
  input  logic              tgt_start,
  input  logic              tgt_dir,
  input  logic              tgt_abort,
  input  logic [DATA_W-1:0] tgt_wdata,
  output logic [DATA_W-1:0] tgt_rdata,
  output logic              tgt_busy,
  output logic              tgt_done,
  output logic              tgt_err,
  input  logic              nACK,
  output logic              nREQ,
  output logic [DATA_W-1:0] db_out,
  output logic              db_oe,
  input  logic [DATA_W-1:0] db_in
`ifdef SCSI_TGT_PARITY_EN
  ,
  output logic              db_p_out,
  input  logic              db_p_in,
  output logic              tgt_perr
`endif
);

  tgt_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [DATA_W-1:0] db_out_q, db_out_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              nreq_q, nreq_d;
  logic              db_oe_q, db_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef SCSI_TGT_PARITY_EN
  logic              db_p_q, db_p_d;
  logic              perr_q, perr_d;
`endif

  logic nack_s;
  logic ack_s;
  logic start_ok;
  logic abort_ok;
  logic settle_hit;
  logic timeout_hit;
  logic capture;

  // nACK negated (high) out of reset so a fresh engine never sees a phantom ACK
  sync2_asyncres #(
    .W       (1),
    .RST_VAL (1'b1)
  ) u_ack_sync (
    .clk   (CLK),
    .rst_n (nCLR),
    .d     (nACK),
    .q     (nack_s)
  );

  assign ack_s       = ~nack_s;
  assign start_ok    = (state_q == ST_IDLE) && tgt_start;
  assign abort_ok    = (state_q != ST_IDLE) && tgt_abort;
  assign settle_hit  = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State and output registers
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dir_q    <= DIR_OUT;
      db_out_q <= '0;
      rdata_q  <= '0;
      nreq_q   <= 1'b1;
      db_oe_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef SCSI_TGT_PARITY_EN
      db_p_q   <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      db_out_q <= db_out_d;
      rdata_q  <= rdata_d;
      nreq_q   <= nreq_d;
      db_oe_q  <= db_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef SCSI_TGT_PARITY_EN
      db_p_q   <= db_p_d;
      perr_q   <= perr_d;
`endif
    end
  end

  // Next state; one counter serves the settle delay and both wait timeouts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tgt_start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (settle_hit) begin
          state_d = ST_REQ_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REQ_WAIT: begin
        if (ack_s) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LATCH: begin
        state_d = ST_REL_WAIT;
        cnt_d   = '0;
      end
      ST_REL_WAIT: begin
        if (!ack_s) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort outranks ACK and timeout
    if (abort_ok) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // Registered outputs follow the state being entered
  always_comb begin
    dir_d    = dir_q;
    db_out_d = db_out_q;
    rdata_d  = rdata_q;
    capture  = (state_q == ST_LATCH) && (state_d == ST_REL_WAIT) && (dir_q == DIR_OUT);
    if (start_ok) begin
      dir_d = tgt_dir;
      if (tgt_dir == DIR_IN) db_out_d = tgt_wdata;
    end
    if (capture) rdata_d = db_in;
    nreq_d  = !(state_d inside {ST_REQ_WAIT, ST_LATCH});
    db_oe_d = (dir_d == DIR_IN) &&
              (state_d inside {ST_SETUP, ST_REQ_WAIT, ST_LATCH, ST_REL_WAIT});
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERR);
`ifdef SCSI_TGT_PARITY_EN
    perr_d = perr_q;
    if (start_ok) perr_d = 1'b0;
    if (capture && !(^{db_in, db_p_in})) perr_d = 1'b1;
    db_p_d = db_oe_d & ~(^db_out_d);
`endif
  end

  assign tgt_rdata = rdata_q;
  assign tgt_busy  = busy_q;
  assign tgt_done  = done_q;
  assign tgt_err   = err_q;
  assign nREQ      = nreq_q;
  assign db_out    = db_out_q;
  assign db_oe     = db_oe_q;
`ifdef SCSI_TGT_PARITY_EN
  assign db_p_out  = db_p_q;
  assign tgt_perr  = perr_q;
`endif

endmodule

// File: doc/scsi_target_handshake.md
Name: scsi_target_handshake

Overview:
- Target-side (responder) SCSI REQ/ACK byte handshake engine for the BeebSCSI CPLD.
- The AVR drive emulator requests one byte transfer at a time; the block paces it against the host adapter's nACK.
- Drives nREQ and the data bus for target-to-initiator transfers.
- Captures bus data on ACK for initiator-to-target transfers.
- Reports done, timeout and abort outcomes back to the AVR side.

Parameters:
- DATA_W, 8: data bus width in bits.
- SETTLE_CYCLES, 2: data setup cycles before nREQ is asserted. Legal range 1..15.
- TIMEOUT_CYCLES, 50000: maximum cycles spent waiting in REQ_WAIT or REL_WAIT before an error.
- CNT_W, 16: counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock
- nCLR  in  1  reset, asynchronous, active-low
- tgt_start  in  1  one-cycle pulse; begins a byte transfer. Sampled only in IDLE.
- tgt_dir  in  1  1 = target to initiator (data-in); 0 = initiator to target (data-out). Sampled with tgt_start.
- tgt_abort  in  1  level; forces the engine back to IDLE
- tgt_wdata  in  DATA_W  byte to send; sampled with tgt_start
- tgt_rdata  out  DATA_W  byte captured from the bus
- tgt_busy  out  1  high whenever the state is not IDLE
- tgt_done  out  1  one-cycle pulse on successful completion
- tgt_err  out  1  one-cycle pulse on timeout
- nACK  in  1  initiator acknowledge, active-low, asynchronous to CLK
- nREQ  out  1  target request, active-low
- db_out  out  DATA_W  bus data driven by the target
- db_oe  out  1  bus output enable
- db_in  in  DATA_W  bus data from the initiator

Behaviour:
- Reset values (nCLR low, asynchronous): nREQ=1, db_oe=0, db_out=0, tgt_rdata=0, tgt_busy=0, tgt_done=0, tgt_err=0, state=IDLE, counters=0, synchroniser flops=1 (ACK negated).
- nACK passes through a 2-flop synchroniser; ack_s is the synchronised active-high ACK. All decisions use ack_s only.
- States: IDLE, SETUP, REQ_WAIT, LATCH, REL_WAIT, DONE, ERR.
- IDLE:
  - tgt_start=1 latches tgt_dir and tgt_wdata, then moves to SETUP.
  - If dir=1, db_out is loaded and db_oe=1 from the next cycle.
- SETUP:
  - Counts SETTLE_CYCLES cycles, then moves to REQ_WAIT.
  - nREQ goes low on the first REQ_WAIT cycle.
  - Net result: nREQ falls SETTLE_CYCLES+1 cycles after the tgt_start cycle.
- REQ_WAIT:
  - nREQ=0. On ack_s=1, go to LATCH.
  - The timeout counter reaching TIMEOUT_CYCLES goes to ERR.
- LATCH:
  - If dir=0, tgt_rdata <= db_in. tgt_rdata is unchanged when dir=1.
  - nREQ returns to 1 on the next cycle. Go to REL_WAIT.
- REL_WAIT:
  - nREQ=1. On ack_s=0, go to DONE.
  - The timeout counter reaching TIMEOUT_CYCLES goes to ERR.
  - The timeout counter is cleared on entry to each wait state.
- DONE: tgt_done=1 for exactly one cycle; db_oe=0; return to IDLE.
- ERR: tgt_err=1 for exactly one cycle; nREQ=1; db_oe=0; return to IDLE.
- tgt_abort=1 in any state except IDLE:
  - Next state is IDLE; nREQ=1 and db_oe=0 from the next cycle.
  - No done or err pulse is produced.
  - tgt_abort has priority over ACK and timeout events in the same cycle.
- tgt_start outside IDLE is ignored; there is no queueing.
- ack_s already high on entry to REQ_WAIT (stale ACK): accepted as the handshake. The AVR firmware guarantees ACK is negated before start.
- db_out holds its value until the next dir=1 start. Only db_oe gates the bus.
- Minimum transfer with ACK responding immediately: SETTLE_CYCLES + 8 cycles, start to done pulse inclusive.

Optional Feature:
- Macro SCSI_TGT_PARITY_EN.
- When defined:
  - Adds output db_p_out (odd parity of db_out, enabled by db_oe), input db_p_in, and output tgt_perr.
  - tgt_perr is a sticky flag, set in LATCH when dir=0 and db_in plus db_p_in is not odd parity.
  - tgt_perr is cleared by tgt_start or reset.
- When undefined: these ports and the parity logic do not exist; behaviour is otherwise identical.

Decomposition:
- Package scsi_tgt_pkg holds:
  - state enum encoding;
  - DIR_IN=1 and DIR_OUT=0 constants;
  - default SETTLE and TIMEOUT constants.
- Sub-module sync2_asyncres: 2-flop synchroniser with async active-low reset and a preset value parameter. It is instantiated for nACK and reused elsewhere in the CPLD.

Test Plan:
- Reset mid-transfer: assert nCLR during REQ_WAIT -> nREQ=1, db_oe=0, busy=0 immediately, without waiting for CLK.
- Data-in: start, dir=1, wdata=0xA5, ACK responds 3 cycles after nREQ falls -> db_out=0xA5 with db_oe=1 before nREQ falls, nREQ low after exactly 3 cycles, one done pulse, db_oe=0 afterwards.
- Data-out: dir=0, initiator drives db_in=0x3C while asserting ACK -> tgt_rdata=0x3C, done pulse, nREQ released before ACK negated.
- Timeout: TIMEOUT_CYCLES=20, ACK never asserted -> one err pulse 20 cycles into REQ_WAIT, nREQ=1, no done pulse.
- Abort coincident with ACK in REQ_WAIT -> returns to IDLE, no done/err pulse, tgt_rdata unchanged.
- Parity (SCSI_TGT_PARITY_EN): db_in=0x01 with db_p_in=1 -> tgt_perr=1; with db_p_in=0 -> tgt_perr stays 0; db_out=0x03 -> db_p_out=1.
